// File: rtl/wire_sampler_if.sv
// Handshake bundle between the wire sampler and its producer/consumer.
// master drives w/start/ready; slave (the sampler) returns the captured frame and status.
interface wire_sampler_if #(
    parameter int NBITS = 8
);
    logic             w;
    logic             start;
    logic             ready;
    logic [NBITS-1:0] data;
    logic             valid;
    logic             busy;
    logic [3:0]       z_cnt;
    logic             x_err;

    modport master (
        output w, start, ready,
        input  data, valid, busy, z_cnt, x_err
    );

    modport slave (
        input  w, start, ready,
        output data, valid, busy, z_cnt, x_err
    );
endinterface

// File: rtl/wire_sampler.sv
// Captures NBITS samples of a shared tri-state wire after a settle delay, MSB first.
// Optional Z/X classification is compiled in by defining WIRE_SAMPLER_ZX_DETECT_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs from the last frame cleared on start
// SETTLE | SETTLE_CYC cycles for the gate stage to drive w; w ignored
// SHIFT  | one sample per edge shifted into data, NBITS edges total
// DONE   | frame held with valid=1 until ready
module wire_sampler #(
    parameter int SETTLE_CYC = 2,
    parameter int NBITS      = 8
) (
    input  logic           clk,
    input  logic           rst,
    wire_sampler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SHIFT, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);
    localparam logic [3:0] BIT_LOAD    = 4'(NBITS - 1);

    state_t           state;
    logic [3:0]       settle_cnt;
    logic [3:0]       bit_cnt;
    logic [NBITS-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic             s;

    // Only a solid 1 counts as 1; Z and X both land in data as 0.
    assign s = (bus.w === 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        data_q <= '0;
                        busy_q <= 1'b1;
                        if (SETTLE_CYC > 0) begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                            bit_cnt    <= '0;
                        end else begin
                            state   <= SHIFT;
                            bit_cnt <= BIT_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state   <= SHIFT;
                        bit_cnt <= BIT_LOAD;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SHIFT: begin
                    data_q <= {data_q[NBITS-2:0], s};
                    if (bit_cnt == 4'd0) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

`ifdef WIRE_SAMPLER_ZX_DETECT_EN
    logic [3:0] z_cnt_q;
    logic       x_err_q;
    logic       is_z;
    logic       is_x;

    assign is_z = (bus.w === 1'bz);
    assign is_x = (bus.w === 1'bx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_cnt_q <= '0;
            x_err_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            z_cnt_q <= '0;
            x_err_q <= 1'b0;
        end else if (state == SHIFT) begin
            if (is_z && z_cnt_q != 4'd15)
                z_cnt_q <= z_cnt_q + 4'd1;
            if (is_x)
                x_err_q <= 1'b1;
        end
    end

    assign bus.z_cnt = z_cnt_q;
    assign bus.x_err = x_err_q;
`else
    assign bus.z_cnt = 4'd0;
    assign bus.x_err = 1'b0;
`endif
endmodule

// File: tb/tb_wire_sampler.sv
// Directed bench for wire_sampler: default instance (SETTLE_CYC=2, NBITS=8) plus a
// SETTLE_CYC=0, NBITS=4 instance.
module tb_wire_sampler;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wire_sampler_if #(.NBITS(8)) mif ();
    wire_sampler_if #(.NBITS(4)) sif ();

    wire_sampler #(.SETTLE_CYC(2), .NBITS(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    wire_sampler #(.SETTLE_CYC(0), .NBITS(4)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WIRE_SAMPLER_ZX_DETECT_EN
    localparam logic [3:0] Z_EXP = 4'd2;
    localparam logic       X_EXP = 1'b1;
`else
    localparam logic [3:0] Z_EXP = 4'd0;
    localparam logic       X_EXP = 1'b0;
`endif

    // Start at edge 0, hold w=1 through settle, samples on edges 3..10; returns at
    // the negedge after edge 10.
    task automatic run_frame(input logic [7:0] bits, input logic [7:0] zmask,
                             input logic [7:0] xmask, input logic rdy,
                             output logic v9, output logic b0);
        @(negedge clk);
        mif.start = 1'b1;
        mif.ready = rdy;
        mif.w     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        b0 = mif.busy;
        v9 = 1'bx;
        for (int e = 1; e <= 10; e++) begin
            if (e >= 3) begin
                int i;
                i = e - 3;
                if (zmask[7-i])      mif.w = 1'bz;
                else if (xmask[7-i]) mif.w = 1'bx;
                else                 mif.w = bits[7-i];
            end else begin
                mif.w = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (e == 9) v9 = mif.valid;
        end
        mif.w = 1'b0;
    endtask

    task automatic accept();
        mif.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mif.w = 1'b0; mif.start = 1'b0; mif.ready = 1'b0;
        sif.w = 1'b0; sif.start = 1'b0; sif.ready = 1'b0;
        #1;
        checks++;
        if (mif.data !== 8'h00 || mif.valid !== 1'b0 || mif.busy !== 1'b0 ||
            mif.z_cnt !== 4'd0 || mif.x_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_main: data=%h valid=%b busy=%b z_cnt=%0d x_err=%b, required all zero",
                     mif.data, mif.valid, mif.busy, mif.z_cnt, mif.x_err);
        end
        checks++;
        if (sif.data !== 4'h0 || sif.valid !== 1'b0 || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_small: data=%h valid=%b busy=%b, required all zero",
                     sif.data, sif.valid, sif.busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic v9, b0;
        run_frame(8'hB2, 8'h00, 8'h00, 1'b0, v9, b0);
        checks++;
        if (b0 !== 1'b1) begin
            errors++; $display("FAIL basic_busy_after_start: busy=%b required 1", b0);
        end
        checks++;
        if (v9 !== 1'b0) begin
            errors++; $display("FAIL basic_valid_early: valid after edge 9=%b required 0", v9);
        end
        checks++;
        if (mif.valid !== 1'b1 || mif.data !== 8'hB2 || mif.z_cnt !== 4'd0 || mif.x_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame: valid=%b data=%h z_cnt=%0d x_err=%b, required 1 b2 0 0",
                     mif.valid, mif.data, mif.z_cnt, mif.x_err);
        end
        accept();
        checks++;
        if (mif.valid !== 1'b0 || mif.busy !== 1'b0) begin
            errors++; $display("FAIL basic_accept: valid=%b busy=%b required 0 0", mif.valid, mif.busy);
        end
    endtask

    // ready held high for the whole frame: no effect until DONE, then accepted at once.
    task automatic test_z_samples();
        logic v9, b0;
        run_frame(8'hB2, 8'b0010_0100, 8'h00, 1'b1, v9, b0);
        checks++;
        if (v9 !== 1'b0 || b0 !== 1'b1) begin
            errors++; $display("FAIL z_ready_early: valid@9=%b busy@0=%b required 0 1", v9, b0);
        end
        checks++;
        if (mif.valid !== 1'b1 || mif.data !== 8'h92 || mif.z_cnt !== Z_EXP) begin
            errors++;
            $display("FAIL z_frame: valid=%b data=%h z_cnt=%0d, required 1 92 %0d",
                     mif.valid, mif.data, mif.z_cnt, Z_EXP);
        end
        @(posedge clk);
        @(negedge clk);
        mif.ready = 1'b0;
        checks++;
        if (mif.valid !== 1'b0 || mif.busy !== 1'b0) begin
            errors++; $display("FAIL z_accept: valid=%b busy=%b required 0 0", mif.valid, mif.busy);
        end
    endtask

    task automatic test_x_sample();
        logic v9, b0;
        logic [7:0] xm;
`ifdef WIRE_SAMPLER_ZX_DETECT_EN
        xm = 8'b0000_1000;
`else
        xm = 8'h00;
`endif
        run_frame(8'hA5, 8'h00, xm, 1'b0, v9, b0);
        checks++;
        if (mif.valid !== 1'b1 || mif.x_err !== X_EXP || mif.data !== (8'hA5 & ~xm)) begin
            errors++;
            $display("FAIL x_frame: valid=%b x_err=%b data=%h, required 1 %b %h",
                     mif.valid, mif.x_err, mif.data, X_EXP, 8'hA5 & ~xm);
        end
        accept();
        run_frame(8'h3C, 8'h00, 8'h00, 1'b0, v9, b0);
        checks++;
        if (mif.x_err !== 1'b0 || mif.data !== 8'h3C) begin
            errors++; $display("FAIL x_cleared: x_err=%b data=%h required 0 3c", mif.x_err, mif.data);
        end
        accept();
    endtask

    task automatic test_hold_done();
        logic v9, b0;
        int bad;
        run_frame(8'hB2, 8'h00, 8'h00, 1'b0, v9, b0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            mif.start = (c % 3 == 1);
            mif.w     = c[0];
            @(posedge clk);
            @(negedge clk);
            if (mif.data !== 8'hB2 || mif.valid !== 1'b1 || mif.busy !== 1'b1) bad++;
        end
        mif.start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_done: %0d of 20 cycles lost frame, last data=%h valid=%b busy=%b, required b2 1 1",
                     bad, mif.data, mif.valid, mif.busy);
        end
        mif.start = 1'b1;
        mif.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        mif.ready = 1'b0;
        checks++;
        if (mif.valid !== 1'b0 || mif.busy !== 1'b0) begin
            errors++; $display("FAIL hold_ready_start: valid=%b busy=%b required 0 0", mif.valid, mif.busy);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mif.busy !== 1'b0) begin
            errors++; $display("FAIL hold_no_restart: busy=%b required 0", mif.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic v9, b0;
        logic [2:0] part;
        part = 3'b101;
        @(negedge clk);
        mif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            mif.w = (e >= 3) ? part[5-e] : 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (mif.data !== 8'h05 || mif.busy !== 1'b1) begin
            errors++; $display("FAIL mid_partial: data=%h busy=%b required 05 1", mif.data, mif.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mif.data !== 8'h00 || mif.valid !== 1'b0 || mif.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: data=%h valid=%b busy=%b required 00 0 0",
                     mif.data, mif.valid, mif.busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_frame(8'h5C, 8'h00, 8'h00, 1'b0, v9, b0);
        checks++;
        if (v9 !== 1'b0 || mif.valid !== 1'b1 || mif.data !== 8'h5C) begin
            errors++;
            $display("FAIL mid_new_frame: valid@9=%b valid=%b data=%h required 0 1 5c",
                     v9, mif.valid, mif.data);
        end
        accept();
    endtask

    task automatic test_no_settle();
        @(negedge clk);
        sif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        sif.w     = 1'b1;
        checks++;
        if (sif.busy !== 1'b1 || sif.valid !== 1'b0) begin
            errors++; $display("FAIL small_start: busy=%b valid=%b required 1 0", sif.busy, sif.valid);
        end
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 3) begin
                checks++;
                if (sif.valid !== 1'b0 || sif.data !== 4'h7) begin
                    errors++;
                    $display("FAIL small_edge3: valid=%b data=%h required 0 7", sif.valid, sif.data);
                end
            end
        end
        checks++;
        if (sif.valid !== 1'b1 || sif.data !== 4'hF) begin
            errors++; $display("FAIL small_frame: valid=%b data=%h required 1 f", sif.valid, sif.data);
        end
        sif.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.ready = 1'b0;
        sif.w     = 1'b0;
        checks++;
        if (sif.valid !== 1'b0 || sif.busy !== 1'b0) begin
            errors++; $display("FAIL small_accept: valid=%b busy=%b required 0 0", sif.valid, sif.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_z_samples();
        test_x_sample();
        test_hold_done();
        test_reset_mid();
        test_no_settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
